mem_byte_fetcher: RTL and testbench

Sequencer that fetches 1–4 consecutive bytes from the byte-wide synchronous data memory and assembles them into a 32-bit word. It sits directly upstream of the 32-bit general/address registers and drives their `E`, `FunSel` and `I` inputs. In big-endian mode it uses the register's own load-low-byte (100) and 8-bit-left-shift (110) modes, so the word builds up in place. It also holds its own copy of the assembled word for status and debug.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/word_assembler.sv | 57 +++++
 rtl/mem_byte_fetcher.sv | 130 +++++++++++++
 tb/tb_mem_byte_fetcher.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for mem_byte_fetcher.
//   state_e    : fetch sequencer states
//   FS_*       : function-select codes of the downstream 32-bit register
//   norm_count : maps a raw 3-bit byte count onto 1..4
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StCap  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [2:0] FS_LOAD8  = 3'b100;  // load low byte, zero upper bytes
  localparam logic [2:0] FS_SHL8   = 3'b110;  // shift left 8, insert low byte
  localparam logic [2:0] FS_LOAD32 = 3'b010;  // full 32-bit load

  // 0 and 5..7 are treated as a full word.
  function automatic logic [2:0] norm_count(input logic [2:0] n);
    return ((n == 3'd0) || (n > 3'd4)) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Holds the assembled 32-bit word for mem_byte_fetcher.
//   clk_i, rst_ni : clock, async active-low reset (word resets to 0)
//   clear_i       : zero the word (takes priority over capture)
//   cap_i         : capture byte_i
//   byte_i        : captured byte
//   idx_i         : byte index within the fetch (0 = first byte)
//   word_o        : assembled word
// FETCH_LITTLE_ENDIAN_EN selects indexed insert (first byte least significant);
// otherwise each byte is shifted in from the right (first byte most significant).
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        cap_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  idx_i,
  output logic [31:0] word_o
);

  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (clear_i) begin
      word_d = '0;
    end else if (cap_i) begin
`ifdef FETCH_LITTLE_ENDIAN_EN
      unique case (idx_i)
        2'd0: word_d[7:0]   = byte_i;
        2'd1: word_d[15:8]  = byte_i;
        2'd2: word_d[23:16] = byte_i;
        2'd3: word_d[31:24] = byte_i;
        default: word_d = word_q;
      endcase
`else
      word_d = {word_q[23:0], byte_i};
`endif
    end
  end

`ifndef FETCH_LITTLE_ENDIAN_EN
  // Shift mode does not need the byte position.
  logic unused_idx;
  assign unused_idx = ^idx_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/mem_byte_fetcher.sv
// Fetches 1..4 consecutive bytes from a byte-wide synchronous memory and
// assembles them into a 32-bit word, driving a downstream 32-bit register.
//   Clock, Reset        : rising-edge clock, async active-low reset
//   Start               : request a fetch (honoured only when idle)
//   BaseAddr, NumBytes  : first byte address and byte count (0/5..7 -> 4)
//   MemAddr, MemRd      : memory request (MemAddr is 0 when not reading)
//   MemData             : read data, valid the cycle after MemRd
//   RegE/RegFunSel/RegI : downstream register controls
//   Word                : local copy of the assembled word
//   Busy, Done          : fetch in progress / one-cycle completion pulse
// Build option FETCH_LITTLE_ENDIAN_EN: first byte least significant and the
// downstream register receives one full load in the DONE cycle.
module mem_byte_fetcher
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [2:0]        NumBytes,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [7:0]        MemData,
  output logic              RegE,
  output logic [2:0]        RegFunSel,
  output logic [31:0]       RegI,
  output logic [31:0]       Word,
  output logic              Busy,
  output logic              Done
);

  state_e            state_q, state_d;
  logic              start_q;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        num_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        rem_q, rem_d;
  logic [1:0]        idx_q, idx_d;
  logic              clear, cap;

  // Start and its operands pass through an input register before IDLE acts on
  // them; this gives the 2N+1 Start-to-Done latency and lets a Start seen in
  // the DONE cycle launch the next fetch.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      start_q <= 1'b0;
      base_q  <= '0;
      num_q   <= '0;
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      start_q <= Start;
      base_q  <= BaseAddr;
      num_q   <= NumBytes;
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    clear   = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          addr_d  = base_q;
          rem_d   = norm_count(num_q);
          idx_d   = 2'd0;
          clear   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: state_d = StCap;
      StCap: begin
        cap     = 1'b1;
        rem_d   = rem_q - 3'd1;
        addr_d  = addr_q + 1'b1;  // wraps modulo 2^ADDR_W
        idx_d   = idx_q + 2'd1;
        state_d = (rem_q == 3'd1) ? StDone : StReq;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  word_assembler u_word_assembler (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .clear_i (clear),
    .cap_i   (cap),
    .byte_i  (MemData),
    .idx_i   (idx_q),
    .word_o  (Word)
  );

  always_comb begin
    MemRd     = (state_q == StReq);
    MemAddr   = MemRd ? addr_q : '0;
    Busy      = (state_q == StReq) || (state_q == StCap);
    Done      = (state_q == StDone);
    RegE      = 1'b0;
    RegFunSel = 3'b000;
    RegI      = 32'h0;
`ifdef FETCH_LITTLE_ENDIAN_EN
    if (state_q == StDone) begin
      RegE      = 1'b1;
      RegFunSel = FS_LOAD32;
      RegI      = Word;
    end
`else
    // Downstream register builds the word in place, mirroring Word.
    if (state_q == StCap) begin
      RegE      = 1'b1;
      RegFunSel = (idx_q == 2'd0) ? FS_LOAD8 : FS_SHL8;
      RegI      = {24'h0, MemData};
    end
`endif
  end

endmodule

// File: tb/tb_mem_byte_fetcher.sv
module tb_mem_byte_fetcher;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] BaseAddr;
  logic [2:0]  NumBytes;
  logic [15:0] MemAddr;
  logic        MemRd;
  logic [7:0]  MemData = 8'h00;
  logic        RegE;
  logic [2:0]  RegFunSel;
  logic [31:0] RegI;
  logic [31:0] Word;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:65535];

  mem_byte_fetcher #(.ADDR_W(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .BaseAddr  (BaseAddr),
    .NumBytes  (NumBytes),
    .MemAddr   (MemAddr),
    .MemRd     (MemRd),
    .MemData   (MemData),
    .RegE      (RegE),
    .RegFunSel (RegFunSel),
    .RegI      (RegI),
    .Word      (Word),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clock = ~Clock;

  // Synchronous byte memory: data appears the cycle after the read strobe.
  always @(posedge Clock) begin
    if (MemRd) MemData <= mem[MemAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memaddr"}, {16'h0, MemAddr}, 32'h0);
    chk({tag, "_memrd"}, {31'h0, MemRd}, 32'h0);
    chk({tag, "_rege"}, {31'h0, RegE}, 32'h0);
    chk({tag, "_funsel"}, {29'h0, RegFunSel}, 32'h0);
    chk({tag, "_regi"}, RegI, 32'h0);
    chk({tag, "_word"}, Word, 32'h0);
    chk({tag, "_busy"}, {31'h0, Busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, Done}, 32'h0);
  endtask

  // One complete fetch with cycle-by-cycle checks. n is the effective byte
  // count; be_w / le_w are the hand-computed words for each byte order.
  task automatic do_fetch(input logic [15:0] base, input logic [2:0] nb, input int n,
                          input logic [31:0] be_w, input logic [31:0] le_w);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] a;
`ifdef FETCH_LITTLE_ENDIAN_EN
    w = le_w;
`else
    w = be_w;
`endif
    @(negedge Clock);
    Start = 1'b1; BaseAddr = base; NumBytes = nb;
    @(posedge Clock); #1;  // edge t
    Start = 1'b0;
    chk("gap_busy", {31'h0, Busy}, 32'h0);
    chk("gap_memrd", {31'h0, MemRd}, 32'h0);
    for (int k = 0; k < n; k++) begin
      a = base + k[15:0];
      @(posedge Clock); #1;
      chk("req_memrd", {31'h0, MemRd}, 32'h1);
      chk("req_memaddr", {16'h0, MemAddr}, {16'h0, a});
      chk("req_busy", {31'h0, Busy}, 32'h1);
      chk("req_rege", {31'h0, RegE}, 32'h0);
      @(posedge Clock); #1;
      chk("cap_memrd", {31'h0, MemRd}, 32'h0);
      chk("cap_memaddr", {16'h0, MemAddr}, 32'h0);
      chk("cap_busy", {31'h0, Busy}, 32'h1);
`ifdef FETCH_LITTLE_ENDIAN_EN
      b = w[8*k +: 8];
      chk("cap_rege", {31'h0, RegE}, 32'h0);
`else
      b = w[8*(n-1-k) +: 8];
      chk("cap_rege", {31'h0, RegE}, 32'h1);
      chk("cap_funsel", {29'h0, RegFunSel}, (k == 0) ? 32'h4 : 32'h6);
      chk("cap_regi", RegI, {24'h0, b});
`endif
    end
    @(posedge Clock); #1;
    chk("done_pulse", {31'h0, Done}, 32'h1);
    chk("done_busy", {31'h0, Busy}, 32'h0);
    chk("done_word", Word, w);
`ifdef FETCH_LITTLE_ENDIAN_EN
    chk("done_rege", {31'h0, RegE}, 32'h1);
    chk("done_funsel", {29'h0, RegFunSel}, 32'h2);
    chk("done_regi", RegI, w);
`else
    chk("done_rege", {31'h0, RegE}, 32'h0);
`endif
    @(posedge Clock); #1;
    chk("idle_done", {31'h0, Done}, 32'h0);
    chk("idle_rege", {31'h0, RegE}, 32'h0);
    chk("hold_word", Word, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bit seen;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'h0020] = 8'hAB; mem[16'h0021] = 8'hCD;
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;

    Reset = 1'b0; Start = 1'b0; BaseAddr = '0; NumBytes = '0;
    @(posedge Clock); #1;
    chk_all_zero("rst");
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    chk_all_zero("post_rst");

    // Full word, two bytes, normalised counts, single byte, address wrap.
    do_fetch(16'h0010, 3'd4, 4, 32'h11223344, 32'h44332211);
    do_fetch(16'h0020, 3'd2, 2, 32'h0000ABCD, 32'h0000CDAB);
    do_fetch(16'h0010, 3'd0, 4, 32'h11223344, 32'h44332211);
    do_fetch(16'h0010, 3'd7, 4, 32'h11223344, 32'h44332211);
    do_fetch(16'h0020, 3'd1, 1, 32'h000000AB, 32'h000000AB);
    do_fetch(16'hFFFF, 3'd2, 2, 32'h00005AA5, 32'h0000A55A);

    // Start held high: one fetch, the next only after DONE/IDLE.
    @(negedge Clock);
    Start = 1'b1; BaseAddr = 16'h0010; NumBytes = 3'd4;
    @(posedge Clock); #1;  // edge t
    for (int e = 1; e <= 9; e++) begin
      @(posedge Clock); #1;
      if ((e % 2) == 1 && e <= 7) begin
        chk("hold_memaddr", {16'h0, MemAddr}, 32'h10 + (e - 1) / 2);
        chk("hold_memrd", {31'h0, MemRd}, 32'h1);
      end
      chk("hold_done", {31'h0, Done}, (e == 9) ? 32'h1 : 32'h0);
    end
    @(posedge Clock); #1;
    chk("hold_idle_busy", {31'h0, Busy}, 32'h0);
    chk("hold_idle_memrd", {31'h0, MemRd}, 32'h0);
    @(posedge Clock); #1;
    chk("hold_restart_rd", {31'h0, MemRd}, 32'h1);
    chk("hold_restart_addr", {16'h0, MemAddr}, 32'h10);
    Start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(posedge Clock); #1;
      if (Done) seen = 1'b1;
    end
    chk("hold_second_done", {31'h0, seen}, 32'h1);
    chk("hold_second_word", Word, 32'h11223344 ^ 32'h0 ^
`ifdef FETCH_LITTLE_ENDIAN_EN
        (32'h11223344 ^ 32'h44332211)
`else
        32'h0
`endif
        );
    @(posedge Clock); #1;
    chk("hold_end_busy", {31'h0, Busy}, 32'h0);

    // Reset during the second CAP.
    @(negedge Clock);
    Start = 1'b1; BaseAddr = 16'h0010; NumBytes = 3'd4;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    chk("mid_cap_busy", {31'h0, Busy}, 32'h1);
    chk("mid_cap_funsel", {29'h0, RegFunSel},
`ifdef FETCH_LITTLE_ENDIAN_EN
        32'h0
`else
        32'h6
`endif
        );
    #1; Reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock); #1;
      chk("rst_no_done", {31'h0, Done}, 32'h0);
    end
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    chk("after_rst_busy", {31'h0, Busy}, 32'h0);
    chk("after_rst_done", {31'h0, Done}, 32'h0);
    do_fetch(16'h0020, 3'd2, 2, 32'h0000ABCD, 32'h0000CDAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
